grid_move_arbiter: RTL

Sequences all player actions onto the shared single-port arena/bomb grid memory (10x10, row-major, index = x*GRID_W + y). Accepts move/bomb requests from player A (buttons) and player B (keypad decoder), arbitrates them round-robin, and performs read-check-write on the grid. It also owns the authoritative player positions. It replaces the per-player parallel writers, so only one requester touches the grid at a time.

---
 rtl/grid_move_arbiter_if.sv | 35 +++
 rtl/grid_move_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/grid_move_arbiter_if.sv
// rtl/grid_move_arbiter_if.sv - request, grid memory and completion bus of the move arbiter
interface grid_move_arbiter_if #(
  parameter int ADDR_W = 7
);
  logic              reqA_valid;
  logic [2:0]        reqA_cmd;
  logic              reqA_ready;
  logic              reqB_valid;
  logic [2:0]        reqB_cmd;
  logic              reqB_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [1:0]        arena_rd_data;
  logic [1:0]        bomb_rd_data;
  logic              arena_wr_en;
  logic              bomb_wr_en;
  logic [1:0]        mem_wr_data;
  logic              done_valid;
  logic              done_player;
  logic              done_ok;

  // master: requesters, grid memory and completion consumer
  modport master (
    output reqA_valid, reqA_cmd, reqB_valid, reqB_cmd, arena_rd_data, bomb_rd_data,
    input  reqA_ready, reqB_ready, mem_addr, mem_rd_en, arena_wr_en, bomb_wr_en,
           mem_wr_data, done_valid, done_player, done_ok
  );

  // slave: the arbiter itself
  modport slave (
    input  reqA_valid, reqA_cmd, reqB_valid, reqB_cmd, arena_rd_data, bomb_rd_data,
    output reqA_ready, reqB_ready, mem_addr, mem_rd_en, arena_wr_en, bomb_wr_en,
           mem_wr_data, done_valid, done_player, done_ok
  );
endinterface

// File: rtl/grid_move_arbiter.sv
// rtl/grid_move_arbiter.sv - round-robin read-check-write sequencer for player moves and bombs
module grid_move_arbiter #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 10,
  parameter int ADDR_W = 7,
  parameter int A_X0   = 0,
  parameter int A_Y0   = 0,
  parameter int B_X0   = 9,
  parameter int B_Y0   = 9
) (
  input  logic                clk,
  input  logic                rst,
  grid_move_arbiter_if.slave  bus,
  output logic [3:0]          playerAx,
  output logic [3:0]          playerAy,
  output logic [3:0]          playerBx,
  output logic [3:0]          playerBy
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_WR_DST, S_WR_SRC, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        player_q, player_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [3:0]  sx_q, sx_d, sy_q, sy_d, dx_q, dx_d, dy_q, dy_d;
  logic        ok_q, ok_d;
  logic        last_b_q, last_b_d;
  logic [3:0]  pax_q, pax_d, pay_q, pay_d, pbx_q, pbx_d, pby_q, pby_d;

  logic              ready_a, ready_b, rd_en, aw_en, bw_en, done_v, gnt_b, legal;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        wdata;
  logic [2:0]        cmd_in;
  logic [3:0]        cur_x, cur_y, nx, ny;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] x, input logic [3:0] y);
    logic [ADDR_W-1:0] xe, ye;
    xe = ADDR_W'(x);
    ye = ADDR_W'(y);
    return xe * ADDR_W'(GRID_W) + ye;
  endfunction

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    cmd_d    = cmd_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    ok_d     = ok_q;
    last_b_d = last_b_q;
    pax_d    = pax_q;
    pay_d    = pay_q;
    pbx_d    = pbx_q;
    pby_d    = pby_q;
    ready_a  = 1'b0;
    ready_b  = 1'b0;
    rd_en    = 1'b0;
    aw_en    = 1'b0;
    bw_en    = 1'b0;
    done_v   = 1'b0;
    addr     = '0;
    wdata    = 2'd0;
    // B wins only when A is idle or A was served last
    gnt_b    = bus.reqB_valid && (!bus.reqA_valid || !last_b_q);
    cmd_in   = gnt_b ? bus.reqB_cmd : bus.reqA_cmd;
    cur_x    = gnt_b ? pbx_q : pax_q;
    cur_y    = gnt_b ? pby_q : pay_q;
    nx       = cur_x;
    ny       = cur_y;
    legal    = 1'b1;
    case (cmd_in)
      3'd0: if (cur_x == 4'd0) legal = 1'b0; else nx = cur_x - 4'd1;
      3'd1: if (cur_x == 4'(GRID_H - 1)) legal = 1'b0; else nx = cur_x + 4'd1;
      3'd2: if (cur_y == 4'd0) legal = 1'b0; else ny = cur_y - 4'd1;
      3'd3: if (cur_y == 4'(GRID_W - 1)) legal = 1'b0; else ny = cur_y + 4'd1;
      3'd4: legal = 1'b1;
      default: legal = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.reqA_valid || bus.reqB_valid) begin
          ready_a  = !gnt_b;
          ready_b  = gnt_b;
          player_d = gnt_b;
          last_b_d = gnt_b;
          cmd_d    = cmd_in;
          sx_d     = cur_x;
          sy_d     = cur_y;
          dx_d     = nx;
          dy_d     = ny;
          ok_d     = 1'b0;
          state_d  = legal ? S_RD : S_RESP;
        end
      end
      S_RD: begin
        rd_en   = 1'b1;
        addr    = addr_of(dx_q, dy_q);
        state_d = S_CHK;
      end
      S_CHK: begin
        if (cmd_q == 3'd4)
          state_d = (bus.bomb_rd_data == 2'd0) ? S_WR_DST : S_RESP;
        else
          state_d = (bus.arena_rd_data == 2'd0 && bus.bomb_rd_data == 2'd0) ? S_WR_DST : S_RESP;
      end
      S_WR_DST: begin
        if (cmd_q == 3'd4) begin
          bw_en   = 1'b1;
          addr    = addr_of(sx_q, sy_q);
          wdata   = 2'd3;
          ok_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          aw_en   = 1'b1;
          addr    = addr_of(dx_q, dy_q);
          wdata   = player_q ? 2'd3 : 2'd2;
          state_d = S_WR_SRC;
        end
      end
      S_WR_SRC: begin
        aw_en   = 1'b1;
        addr    = addr_of(sx_q, sy_q);
        ok_d    = 1'b1;
        state_d = S_RESP;
        if (player_q) begin
          pbx_d = dx_q;
          pby_d = dy_q;
        end else begin
          pax_d = dx_q;
          pay_d = dy_q;
        end
      end
      S_RESP: begin
        done_v  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      player_q <= 1'b0;
      cmd_q    <= 3'd0;
      sx_q     <= 4'd0;
      sy_q     <= 4'd0;
      dx_q     <= 4'd0;
      dy_q     <= 4'd0;
      ok_q     <= 1'b0;
      last_b_q <= 1'b1;
      pax_q    <= 4'(A_X0);
      pay_q    <= 4'(A_Y0);
      pbx_q    <= 4'(B_X0);
      pby_q    <= 4'(B_Y0);
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      cmd_q    <= cmd_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      ok_q     <= ok_d;
      last_b_q <= last_b_d;
      pax_q    <= pax_d;
      pay_q    <= pay_d;
      pbx_q    <= pbx_d;
      pby_q    <= pby_d;
    end
  end

  assign bus.reqA_ready  = ready_a;
  assign bus.reqB_ready  = ready_b;
  assign bus.mem_addr    = addr;
  assign bus.mem_rd_en   = rd_en;
  assign bus.arena_wr_en = aw_en;
  assign bus.bomb_wr_en  = bw_en;
  assign bus.mem_wr_data = wdata;
  assign bus.done_valid  = done_v;
  assign bus.done_player = done_v & player_q;
  assign bus.done_ok     = done_v & ok_q;
  assign playerAx        = pax_q;
  assign playerAy        = pay_q;
  assign playerBx        = pbx_q;
  assign playerBy        = pby_q;
endmodule
